// File: rtl/trdb_pkg.sv
// Shared trace-debugger types and constants: packet geometry and the stream
// arbiter FSM encoding.
package trdb_pkg;

   localparam int unsigned PACKET_LEN = 64;
   localparam int unsigned LEN_W      = $clog2(PACKET_LEN);

   typedef enum logic [2:0] {
      ARB_IDLE  = 3'd0,
      ARB_RUN   = 3'd1,
      ARB_DRAIN = 3'd2,
      ARB_FLUSH = 3'd3,
      ARB_DONE  = 3'd4
   } trdb_arb_state_e;

   // New source packets may only be accepted before a flush has started.
   function automatic logic arb_accepts_packets(trdb_arb_state_e s);
      return (s == ARB_IDLE) || (s == ARB_RUN);
   endfunction

endpackage

// File: rtl/trdb_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i
// (wrapping) wins; returns a one-hot grant and the winner index.
module trdb_rr_arbiter #(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_SRC-1:0] grant_o,
   output logic [IDX_W-1:0]   winner_o,
   output logic               valid_o
);

   int unsigned idx_s;

   always_comb begin
      grant_o  = '0;
      winner_o = '0;
      valid_o  = 1'b0;
      idx_s    = 0;
      for (int unsigned off = 0; off < NUM_SRC; off++) begin
         idx_s = (32'(ptr_i) + off) % NUM_SRC;
         if (!valid_o && req_i[idx_s]) begin
            grant_o[idx_s] = 1'b1;
            winner_o       = IDX_W'(idx_s);
            valid_o        = 1'b1;
         end else begin
            grant_o[idx_s] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/trdb_stream_arbiter.sv
// Merges NUM_SRC packet sources into one registered stream towards the aligner
// and sequences the drain/flush handshake. TRDB_ARB_PRIO_EN: source 0 wins always.
module trdb_stream_arbiter
   import trdb_pkg::*;
#(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NUM_SRC-1:0][PACKET_LEN-1:0]  src_bits_i,
   input  logic [NUM_SRC-1:0][LEN_W-1:0]       src_len_i,
   input  logic [NUM_SRC-1:0]                  src_valid_i,
   output logic [NUM_SRC-1:0]                  src_grant_o,
   output logic [PACKET_LEN-1:0]               dst_bits_o,
   output logic [LEN_W-1:0]                    dst_len_o,
   output logic                                dst_valid_o,
   input  logic                                dst_grant_i,
   input  logic                                flush_req_i,
   output logic                                dst_flush_o,
   input  logic                                dst_flush_confirm_i,
   output logic                                flush_done_o,
   output logic [CNT_W-1:0]                    pkt_cnt_o
);

   localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   trdb_arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;
   logic [PACKET_LEN-1:0]   bits_q, bits_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic                    valid_q, valid_d;
   logic                    flush_q, flush_d;
   logic                    done_q, done_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic [NUM_SRC-1:0]      arb_req_s, arb_grant_s, grant_s;
   logic [IDX_W-1:0]        arb_winner_s, winner_s;
   logic [IDX_W:0]          winner_inc_s;
   logic                    arb_valid_s, win_valid_s;
   logic                    accept_s, load_s, fwd_s;
   logic [LEN_W-1:0]        win_len_s;

   trdb_rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req_i    (arb_req_s),
      .ptr_i    (ptr_q),
      .grant_o  (arb_grant_s),
      .winner_o (arb_winner_s),
      .valid_o  (arb_valid_s)
   );

`ifdef TRDB_ARB_PRIO_EN
   // Source 0 pre-empts the rotation; the others share the round-robin.
   always_comb begin
      arb_req_s    = src_valid_i;
      arb_req_s[0] = 1'b0;
      if (src_valid_i[0]) begin
         grant_s     = NUM_SRC'(1);
         winner_s    = '0;
         win_valid_s = 1'b1;
      end else begin
         grant_s     = arb_grant_s;
         winner_s    = arb_winner_s;
         win_valid_s = arb_valid_s;
      end
   end
`else
   always_comb begin
      arb_req_s   = src_valid_i;
      grant_s     = arb_grant_s;
      winner_s    = arb_winner_s;
      win_valid_s = arb_valid_s;
   end
`endif

   // A grant from the aligner only counts while a packet is actually offered.
   assign accept_s     = valid_q && dst_grant_i;
   assign load_s       = rst_ni && arb_accepts_packets(state_q) && win_valid_s
                         && (!valid_q || dst_grant_i);
   assign win_len_s    = src_len_i[winner_s];
   assign fwd_s        = load_s && (win_len_s != {LEN_W{1'b0}});
   assign winner_inc_s = {1'b0, winner_s} + (IDX_W+1)'(1);
   assign src_grant_o  = load_s ? grant_s : {NUM_SRC{1'b0}};

   // Output register, pointer and packet counter next-state.
   always_comb begin
      bits_d = bits_q;
      len_d  = len_q;
      if (fwd_s) begin
         bits_d  = src_bits_i[winner_s];
         len_d   = win_len_s;
         valid_d = 1'b1;
      end else if (accept_s) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      if (!load_s) begin
         ptr_d = ptr_q;
`ifdef TRDB_ARB_PRIO_EN
      end else if (winner_s == {IDX_W{1'b0}}) begin
         ptr_d = ptr_q;
`endif
      end else if (winner_inc_s == (IDX_W+1)'(NUM_SRC)) begin
         ptr_d = '0;
      end else begin
         ptr_d = winner_inc_s[IDX_W-1:0];
      end

      if (accept_s) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Flush sequencing: a flush request is captured by leaving Idle/Run at once.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (flush_req_i) begin
               state_d = ARB_DRAIN;
            end else if (|src_valid_i) begin
               state_d = ARB_RUN;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_RUN: begin
            if (flush_req_i) begin
               state_d = ARB_DRAIN;
            end else begin
               state_d = ARB_RUN;
            end
         end
         ARB_DRAIN: begin
            if (!valid_q) begin
               state_d = ARB_FLUSH;
            end else begin
               state_d = ARB_DRAIN;
            end
         end
         ARB_FLUSH: begin
            if (dst_flush_confirm_i) begin
               state_d = ARB_DONE;
            end else begin
               state_d = ARB_FLUSH;
            end
         end
         ARB_DONE: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
      flush_d = (state_d == ARB_FLUSH);
      done_d  = (state_d == ARB_DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         bits_q  <= '0;
         len_q   <= '0;
         valid_q <= 1'b0;
         flush_q <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         bits_q  <= bits_d;
         len_q   <= len_d;
         valid_q <= valid_d;
         flush_q <= flush_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dst_bits_o   = bits_q;
   assign dst_len_o    = len_q;
   assign dst_valid_o  = valid_q;
   assign dst_flush_o  = flush_q;
   assign flush_done_o = done_q;
   assign pkt_cnt_o    = cnt_q;

endmodule

// File: tb/tb_trdb_stream_arbiter.sv
// Scoreboard bench for trdb_stream_arbiter: directed stimulus pushes expected
// grants/packets into queues, negedge monitors pop and compare.
module tb_trdb_stream_arbiter;
   import trdb_pkg::*;

   localparam int unsigned NSRC = 3;
   localparam int unsigned CW   = 32;

   localparam logic [PACKET_LEN-1:0] P0 = 64'hA0A0_0000_0000_0001;
   localparam logic [PACKET_LEN-1:0] P1 = 64'hB1B1_0000_0000_0002;
   localparam logic [PACKET_LEN-1:0] P2 = 64'hC2C2_0000_0000_0003;
   localparam logic [PACKET_LEN-1:0] P3 = 64'hD3D3_0000_0000_0004;
   localparam logic [PACKET_LEN-1:0] P4 = 64'hE4E4_0000_0000_0005;
   localparam logic [PACKET_LEN-1:0] P5 = 64'hF5F5_0000_0000_0006;

   typedef struct packed {
      logic [PACKET_LEN-1:0] bits;
      logic [LEN_W-1:0]      len;
   } pkt_t;

   logic                             clk_i = 1'b0;
   logic                             rst_ni = 1'b0;
   logic [NSRC-1:0][PACKET_LEN-1:0]  src_bits = '0;
   logic [NSRC-1:0][LEN_W-1:0]       src_len = '0;
   logic [NSRC-1:0]                  src_valid = '0;
   logic [NSRC-1:0]                  src_grant_o;
   logic [PACKET_LEN-1:0]            dst_bits_o;
   logic [LEN_W-1:0]                 dst_len_o;
   logic                             dst_valid_o;
   logic                             dst_grant = 1'b0;
   logic                             flush_req = 1'b0;
   logic                             dst_flush_o;
   logic                             confirm = 1'b0;
   logic                             flush_done_o;
   logic [CW-1:0]                    pkt_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [NSRC-1:0] exp_grant_q[$];
   pkt_t            exp_pkt_q[$];
   logic [NSRC-1:0] mon_g;
   pkt_t            mon_p;

   trdb_stream_arbiter #(.NUM_SRC(NSRC), .CNT_W(CW)) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .src_bits_i          (src_bits),
      .src_len_i           (src_len),
      .src_valid_i         (src_valid),
      .src_grant_o         (src_grant_o),
      .dst_bits_o          (dst_bits_o),
      .dst_len_o           (dst_len_o),
      .dst_valid_o         (dst_valid_o),
      .dst_grant_i         (dst_grant),
      .flush_req_i         (flush_req),
      .dst_flush_o         (dst_flush_o),
      .dst_flush_confirm_i (confirm),
      .flush_done_o        (flush_done_o),
      .pkt_cnt_o           (pkt_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic smp();
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_ni    = 1'b0;
      src_valid = '0;
      src_bits  = '0;
      src_len   = '0;
      dst_grant = 1'b0;
      flush_req = 1'b0;
      confirm   = 1'b0;
      repeat (2) tick();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic push_pkt(input logic [PACKET_LEN-1:0] b, input logic [LEN_W-1:0] l);
      pkt_t p;
      p.bits = b;
      p.len  = l;
      exp_pkt_q.push_back(p);
   endtask

   // Grant monitor: every source grant must match the next expected grant.
   always @(negedge clk_i) begin
      if (rst_ni && (src_grant_o !== '0)) begin
         if (exp_grant_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant_unexpected: got %b, expected no grant", src_grant_o);
         end else begin
            mon_g = exp_grant_q.pop_front();
            chk("grant_order", 64'(src_grant_o), 64'(mon_g));
         end
      end
   end

   // Packet monitor: every aligner handshake must carry the next expected packet.
   always @(negedge clk_i) begin
      if (rst_ni && dst_valid_o && dst_grant) begin
         if (exp_pkt_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pkt_unexpected: got len %0d bits 0x%0h, expected none",
                     dst_len_o, dst_bits_o);
         end else begin
            mon_p = exp_pkt_q.pop_front();
            chk("pkt_bits", 64'(dst_bits_o), 64'(mon_p.bits));
            chk("pkt_len", 64'(dst_len_o), 64'(mon_p.len));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int lat;

      // Reset state
      do_reset();
      smp();
      chk("rst_valid", 64'(dst_valid_o), 64'(0));
      chk("rst_bits", 64'(dst_bits_o), 64'(0));
      chk("rst_len", 64'(dst_len_o), 64'(0));
      chk("rst_grant", 64'(src_grant_o), 64'(0));
      chk("rst_flush", 64'(dst_flush_o), 64'(0));
      chk("rst_done", 64'(flush_done_o), 64'(0));
      chk("rst_cnt", 64'(pkt_cnt_o), 64'(0));

      // Two sources, aligner always ready: alternate grants, one packet per cycle
      tick();
      src_bits[0] = P0; src_len[0] = 6'd10;
      src_bits[1] = P1; src_len[1] = 6'd11;
      src_valid = 3'b011;
      dst_grant = 1'b1;
      exp_grant_q.push_back(3'b001); exp_grant_q.push_back(3'b010);
      exp_grant_q.push_back(3'b001); exp_grant_q.push_back(3'b010);
      push_pkt(P0, 6'd10); push_pkt(P1, 6'd11); push_pkt(P0, 6'd10); push_pkt(P1, 6'd11);
      for (int k = 0; k < 4; k++) begin
         smp();
         if (k > 0) chk("t1_throughput", 64'(dst_valid_o), 64'(1));
         tick();
      end
      src_valid = 3'b000;
      smp();
      chk("t1_last_valid", 64'(dst_valid_o), 64'(1));
      tick();
      smp();
      chk("t1_cnt", 64'(pkt_cnt_o), 64'(4));
      chk("t1_empty", 64'(dst_valid_o), 64'(0));

      // Back-pressure: output held stable, no further grants
      do_reset();
      src_bits[0] = P2; src_len[0] = 6'd33; src_valid = 3'b001; dst_grant = 1'b0;
      exp_grant_q.push_back(3'b001);
      push_pkt(P2, 6'd33);
      smp();
      tick();
      for (int k = 0; k < 5; k++) begin
         smp();
         chk("t2_no_grant", 64'(src_grant_o), 64'(0));
         chk("t2_bits_stable", 64'(dst_bits_o), 64'(P2));
         chk("t2_len_stable", 64'(dst_len_o), 64'(33));
         tick();
      end
      src_valid = 3'b000; dst_grant = 1'b1;
      smp();
      tick();
      dst_grant = 1'b0;
      smp();
      chk("t2_cnt", 64'(pkt_cnt_o), 64'(1));

      // Zero-length packet consumed silently, then a 20-bit packet
      do_reset();
      src_bits[0] = P5; src_len[0] = 6'd0; src_valid = 3'b001; dst_grant = 1'b1;
      exp_grant_q.push_back(3'b001);
      smp();
      tick();
      src_bits[0] = P3; src_len[0] = 6'd20;
      exp_grant_q.push_back(3'b001);
      push_pkt(P3, 6'd20);
      smp();
      chk("t3_zero_not_fwd", 64'(dst_valid_o), 64'(0));
      tick();
      src_valid = 3'b000;
      smp();
      chk("t3_len", 64'(dst_len_o), 64'(20));
      tick();
      smp();
      chk("t3_cnt", 64'(pkt_cnt_o), 64'(1));

      // Flush with a packet buffered
      do_reset();
      src_bits[0] = P4; src_len[0] = 6'd8; src_valid = 3'b001; dst_grant = 1'b0;
      exp_grant_q.push_back(3'b001);
      push_pkt(P4, 6'd8);
      smp();
      tick();
      src_valid = 3'b000; flush_req = 1'b1;
      smp();
      tick();
      flush_req = 1'b0; src_valid = 3'b001;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("t4_no_flush_early", 64'(dst_flush_o), 64'(0));
         chk("t4_still_valid", 64'(dst_valid_o), 64'(1));
         tick();
      end
      dst_grant = 1'b1;
      smp();
      tick();
      dst_grant = 1'b0;
      seen = 1'b0;
      lat = -1;
      for (int k = 0; k < 8; k++) begin
         smp();
         chk("t4_flush_vs_valid", 64'(dst_flush_o && dst_valid_o), 64'(0));
         if (dst_flush_o) begin
            seen = 1'b1;
            lat = k;
            break;
         end
         tick();
      end
      chk("t4_flush_seen", 64'(seen), 64'(1));
      chk("t4_flush_latency", 64'(lat), 64'(1));
      tick();
      src_valid = 3'b000; flush_req = 1'b1;
      smp();
      chk("t4_flush_hold1", 64'(dst_flush_o), 64'(1));
      chk("t4_done_early1", 64'(flush_done_o), 64'(0));
      tick();
      flush_req = 1'b0;
      smp();
      chk("t4_flush_hold2", 64'(dst_flush_o), 64'(1));
      chk("t4_done_early2", 64'(flush_done_o), 64'(0));
      tick();
      confirm = 1'b1;
      smp();
      chk("t4_flush_hold3", 64'(dst_flush_o), 64'(1));
      tick();
      confirm = 1'b0;
      smp();
      chk("t4_done_pulse", 64'(flush_done_o), 64'(1));
      chk("t4_flush_off", 64'(dst_flush_o), 64'(0));
      tick();
      smp();
      chk("t4_done_single", 64'(flush_done_o), 64'(0));
      chk("t4_idle", 64'(dut.state_q), 64'(ARB_IDLE));

      // Three sources always valid: rotation, or source 0 under priority
      do_reset();
      src_bits[0] = P0; src_len[0] = 6'd10;
      src_bits[1] = P1; src_len[1] = 6'd11;
      src_bits[2] = P2; src_len[2] = 6'd12;
      src_valid = 3'b111; dst_grant = 1'b1;
`ifdef TRDB_ARB_PRIO_EN
      for (int k = 0; k < 4; k++) begin
         exp_grant_q.push_back(3'b001);
         push_pkt(P0, 6'd10);
      end
`else
      exp_grant_q.push_back(3'b001); exp_grant_q.push_back(3'b010);
      exp_grant_q.push_back(3'b100); exp_grant_q.push_back(3'b001);
      push_pkt(P0, 6'd10); push_pkt(P1, 6'd11); push_pkt(P2, 6'd12); push_pkt(P0, 6'd10);
`endif
      repeat (4) begin
         smp();
         tick();
      end
      src_valid = 3'b000;
      smp();
      tick();
      smp();
      chk("t5_cnt", 64'(pkt_cnt_o), 64'(4));

      // Reset asserted while in Flush
      do_reset();
      src_bits[0] = P4; src_len[0] = 6'd8; src_valid = 3'b001; dst_grant = 1'b1;
      exp_grant_q.push_back(3'b001);
      push_pkt(P4, 6'd8);
      smp();
      tick();
      src_valid = 3'b000;
      smp();
      tick();
      flush_req = 1'b1;
      smp();
      tick();
      flush_req = 1'b0; dst_grant = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         smp();
         if (dst_flush_o) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      chk("t6_in_flush", 64'(seen), 64'(1));
      chk("t6_cnt_before", 64'(pkt_cnt_o), 64'(1));
      #2;
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_flush", 64'(dst_flush_o), 64'(0));
      chk("t6_rst_valid", 64'(dst_valid_o), 64'(0));
      smp();
      chk("t6_rst_cnt", 64'(pkt_cnt_o), 64'(0));
      chk("t6_rst_done", 64'(flush_done_o), 64'(0));
      chk("t6_rst_grant", 64'(src_grant_o), 64'(0));
      chk("t6_rst_bits", 64'(dst_bits_o), 64'(0));
      chk("t6_rst_len", 64'(dst_len_o), 64'(0));
      chk("t6_rst_state", 64'(dut.state_q), 64'(ARB_IDLE));
      tick();
      rst_ni = 1'b1;
      tick();

      chk("sb_grants_drained", 64'(exp_grant_q.size()), 64'(0));
      chk("sb_pkts_drained", 64'(exp_pkt_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
